gshare_spec: RTL and testbench

Parametrised gshare branch predictor for the fetch stage. It adds configurable history length and counter width, and keeps a speculative global history that is updated on every prediction and repaired on a misprediction. Fetch queries it combinationally with the PC. The execute stage returns resolved outcomes, carrying the PHT index and the history snapshot captured at prediction time.

---
 rtl/gshare_spec.sv | 111 +++++++++++
 tb/tb_gshare_spec.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/gshare_spec.sv
// gshare_spec: parametrised gshare branch predictor for the fetch stage.
// A global history register XORed with a PC slice indexes a table of
// saturating counters. Prediction is purely combinational; training and
// history updates take effect on the next rising edge.
// Optional feature macro: GSHARE_SPEC_HIST_EN
//   defined     -> history is shifted speculatively on every consumed
//                  prediction and repaired from the carried snapshot on a
//                  misprediction.
//   not defined -> history only shifts in resolved outcomes; pred_valid_i,
//                  res_mispred_i and res_hist_i are ignored.
// HLEN must be at least 2.

module gshare_spec #(
    parameter int XLEN   = 32,
    parameter int HLEN   = 8,
    parameter int OFFSET = 2,
    parameter int CNT_W  = 2
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            flush_i,
    input  logic            pred_valid_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            taken_o,
    output logic [HLEN-1:0] pred_index_o,
    output logic [HLEN-1:0] pred_hist_o,
    input  logic            res_valid_i,
    input  logic [HLEN-1:0] res_index_i,
    input  logic            res_taken_i,
    input  logic            res_mispred_i,
    input  logic [HLEN-1:0] res_hist_i
);

    localparam int              DEPTH   = 2 ** HLEN;
    localparam logic [CNT_W-1:0] WNT     = CNT_W'((2 ** (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [HLEN-1:0]  history;
    logic [HLEN-1:0]  history_next;
    logic [HLEN-1:0]  pc_slice;
    logic [CNT_W-1:0] pht [DEPTH];

    // Only the hashed slice of the PC matters; the rest is folded into a sink.
    logic unused_pc;
    assign unused_pc = ^pc_i;

    assign pc_slice     = pc_i[HLEN+OFFSET-1:OFFSET];
    assign pred_index_o = history ^ pc_slice;
    assign pred_hist_o  = history;
    assign taken_o      = pht[pred_index_o][CNT_W-1];

`ifdef GSHARE_SPEC_HIST_EN
    // Speculative history: flush, then misprediction repair, then prediction shift.
    always_comb begin
        history_next = history;
        if (flush_i) begin
            history_next = '0;
        end else if (res_valid_i && res_mispred_i) begin
            history_next = {res_taken_i, res_hist_i[HLEN-1:1]};
        end else if (pred_valid_i) begin
            history_next = {taken_o, history[HLEN-1:1]};
        end
    end
`else
    // Non-speculative history: every resolved outcome is shifted in.
    logic unused_spec;
    assign unused_spec = ^{pred_valid_i, res_mispred_i, res_hist_i};

    always_comb begin
        history_next = history;
        if (flush_i) begin
            history_next = '0;
        end else if (res_valid_i) begin
            history_next = {res_taken_i, history[HLEN-1:1]};
        end
    end
`endif

    // Global history register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            history <= '0;
        end else begin
            history <= history_next;
        end
    end

    // Pattern history table: clear to weak-not-taken, otherwise train on resolution.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                pht[i] <= WNT;
            end
        end else if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                pht[i] <= WNT;
            end
        end else if (res_valid_i) begin
            if (res_taken_i) begin
                if (pht[res_index_i] != CNT_MAX) begin
                    pht[res_index_i] <= pht[res_index_i] + CNT_W'(1);
                end
            end else begin
                if (pht[res_index_i] != '0) begin
                    pht[res_index_i] <= pht[res_index_i] - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_gshare_spec.sv
// tb_gshare_spec: directed self-checking bench for gshare_spec with
// HLEN=4, OFFSET=2, CNT_W=2. Expected values are hand-computed for both
// the speculative (GSHARE_SPEC_HIST_EN) and non-speculative builds.

module tb_gshare_spec;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        pred_valid;
    logic [31:0] pc;
    logic        taken;
    logic [3:0]  pred_index;
    logic [3:0]  pred_hist;
    logic        res_valid;
    logic [3:0]  res_index;
    logic        res_taken;
    logic        res_mispred;
    logic [3:0]  res_hist;

    int errors;
    int checks;

    logic [3:0] exp_hist;
    logic [3:0] sat_hist  [7];
    logic       sat_out   [7];
    logic       sat_taken [7];

    gshare_spec #(
        .XLEN   (32),
        .HLEN   (4),
        .OFFSET (2),
        .CNT_W  (2)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .flush_i       (flush),
        .pred_valid_i  (pred_valid),
        .pc_i          (pc),
        .taken_o       (taken),
        .pred_index_o  (pred_index),
        .pred_hist_o   (pred_hist),
        .res_valid_i   (res_valid),
        .res_index_i   (res_index),
        .res_taken_i   (res_taken),
        .res_mispred_i (res_mispred),
        .res_hist_i    (res_hist)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
            $error("[TB] check %s did not match", tag);
        end
    endtask

    // Drive all control/resolution inputs for the coming edge.
    task automatic applyStimulus(input logic fl, input logic pv, input logic rv,
                                 input logic rt, input logic rm,
                                 input logic [3:0] ri, input logic [3:0] rh);
        flush       = fl;
        pred_valid  = pv;
        res_valid   = rv;
        res_taken   = rt;
        res_mispred = rm;
        res_index   = ri;
        res_hist    = rh;
    endtask

    // Advance one edge, then return all pulse inputs to idle.
    task automatic tick();
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        #1;
    endtask

    // PC that hashes to the requested index under the expected history.
    function automatic logic [31:0] pcFor(input logic [3:0] idx);
        return {26'h0, exp_hist ^ idx, 2'b00};
    endfunction

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        pc     = 32'h34;
        exp_hist = 4'h0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);

        sat_taken = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        sat_out   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
`ifdef GSHARE_SPEC_HIST_EN
        sat_hist  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
`else
        sat_hist  = '{4'h8, 4'hC, 4'hE, 4'h7, 4'h3, 4'h1, 4'h0};
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        checkOutput("reset_index", 32'(pred_index), 32'hD);
        checkOutput("reset_hist", 32'(pred_hist), 32'h0);
        checkOutput("reset_taken", 32'(taken), 32'h0);

        // Counter saturation at index 5, with a read-during-write check first
        pc = 32'h14;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h5, 4'h0);
        #1;
        checkOutput("no_bypass_sat", 32'(taken), 32'h0);
        for (int s = 0; s < 7; s++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, sat_taken[s], 1'b0, 4'h5, 4'h0);
            tick();
            exp_hist = sat_hist[s];
            pc = pcFor(4'h5);
            #1;
            checkOutput($sformatf("sat_hist_%0d", s), 32'(pred_hist), 32'(exp_hist));
            checkOutput($sformatf("sat_index_%0d", s), 32'(pred_index), 32'h5);
            checkOutput($sformatf("sat_taken_%0d", s), 32'(taken), 32'(sat_out[s]));
        end

`ifdef GSHARE_SPEC_HIST_EN
        // Speculative update: prime indices 0x0 and 0x8 to weak-taken
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h8, 4'h0);
        tick();
        pc = 32'h0;
        #1;
        checkOutput("prime_hist_hold", 32'(pred_hist), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        #1;
        checkOutput("spec_taken_0", 32'(taken), 32'h1);
        tick();
        checkOutput("spec_hist_0", 32'(pred_hist), 32'h8);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        #1;
        checkOutput("spec_index_1", 32'(pred_index), 32'h8);
        checkOutput("spec_taken_1", 32'(taken), 32'h1);
        tick();
        checkOutput("spec_hist_1", 32'(pred_hist), 32'hC);

        // Recovery beats a simultaneous prediction
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'h7, 4'h3);
        tick();
        checkOutput("recover_hist", 32'(pred_hist), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h7, 4'hF);
        tick();
        checkOutput("correct_res_hold", 32'(pred_hist), 32'h1);
        tick();
        checkOutput("idle_hold", 32'(pred_hist), 32'h1);
        exp_hist = 4'h1;
`else
        // Non-speculative: predictions never touch history
        pc = 32'h0;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        tick();
        checkOutput("nonspec_pv_hold_0", 32'(pred_hist), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        tick();
        checkOutput("nonspec_pv_hold_1", 32'(pred_hist), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 4'h0);
        tick();
        checkOutput("nonspec_shift_0", 32'(pred_hist), 32'h8);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 4'h0);
        tick();
        checkOutput("nonspec_shift_1", 32'(pred_hist), 32'hC);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'hF, 4'hF);
        tick();
        checkOutput("nonspec_shift_2", 32'(pred_hist), 32'h6);
        exp_hist = 4'h6;
`endif

        // Train index 0xA to strong-taken, checking no bypass on the first write
        pc = pcFor(4'hA);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'hA, 4'h0);
        #1;
        checkOutput("no_bypass_train", 32'(taken), 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'hA, 4'h0);
        tick();
`ifdef GSHARE_SPEC_HIST_EN
        exp_hist = 4'h1;
`else
        exp_hist = 4'hD;
`endif
        pc = pcFor(4'hA);
        #1;
        checkOutput("train_hist", 32'(pred_hist), 32'(exp_hist));
        checkOutput("train_taken", 32'(taken), 32'h1);

        // Flush with a concurrent resolution that must be dropped
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h3, 4'h0);
        tick();
        exp_hist = 4'h0;
        checkOutput("flush_hist", 32'(pred_hist), 32'h0);
        pc = 32'h28;
        #1;
        checkOutput("flush_taken_a", 32'(taken), 32'h0);
        pc = 32'h0C;
        #1;
        checkOutput("flush_taken_3", 32'(taken), 32'h0);
        pc = 32'h0;
        #1;
        checkOutput("flush_taken_0", 32'(taken), 32'h0);

        // One taken resolution after flush moves WNT to weak-taken
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'hA, 4'h0);
        tick();
`ifdef GSHARE_SPEC_HIST_EN
        exp_hist = 4'h0;
`else
        exp_hist = 4'h8;
`endif
        pc = pcFor(4'hA);
        #1;
        checkOutput("post_flush_hist", 32'(pred_hist), 32'(exp_hist));
        checkOutput("post_flush_taken", 32'(taken), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
